// File: rtl/pentary_pkg.sv
// Shared pentary digit encoding and quantizer defaults.
package pentary_pkg;

  localparam int FRAC_W_DEF = 16;

  localparam logic [2:0] PENT_NEG2 = 3'b000;
  localparam logic [2:0] PENT_NEG1 = 3'b001;
  localparam logic [2:0] PENT_ZERO = 3'b010;
  localparam logic [2:0] PENT_POS1 = 3'b011;
  localparam logic [2:0] PENT_POS2 = 3'b100;

  function automatic logic [2:0] pent_encode(input int q);
    case (q)
      -2:      return PENT_NEG2;
      -1:      return PENT_NEG1;
      1:       return PENT_POS1;
      2:       return PENT_POS2;
      default: return PENT_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/pentary_quant_lane.sv
// One lane: subtract zero point, scale, round half away from zero, clamp to +/-2.
module pentary_quant_lane
  import pentary_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] zp_i,
  input  logic [DATA_W-1:0] inv_p0_i,
  output logic [2:0]        dig_o,
  output logic              sat_o
);

  localparam int PW = 2*DATA_W + 1;
  localparam int SH = 2*FRAC_W;
  localparam logic [PW:0] HALF = (PW+1)'(1) << (SH-1);
  localparam logic [PW:0] MAG_MAX = (PW+1)'(2);

  logic signed [DATA_W:0] diff_p0_q;
  logic signed [PW-1:0]   prod_p1_q;
  logic [2:0]             dig_p2_q;
  logic                   sat_p2_q;

  logic signed [PW-1:0]   dx_w;
  logic signed [PW-1:0]   ix_w;
  logic [PW:0]            mag_w;
  logic [3:0]             res_w;

  function automatic logic [PW:0] round_mag(input logic signed [PW-1:0] p);
    logic signed [PW:0] pe;
    pe = {p[PW-1], p};
    if (pe[PW]) pe = -pe;
    return (pe + HALF) >> SH;
  endfunction

  function automatic logic [3:0] sat_encode(input logic neg, input logic [PW:0] mag);
    int q;
    if (mag > MAG_MAX) return {1'b1, neg ? PENT_NEG2 : PENT_POS2};
    q = int'(mag[1:0]);
    return {1'b0, pent_encode(neg ? -q : q)};
  endfunction

  assign dx_w  = {{DATA_W{diff_p0_q[DATA_W]}}, diff_p0_q};
  assign ix_w  = {{(DATA_W+1){inv_p0_i[DATA_W-1]}}, inv_p0_i};
  assign mag_w = round_mag(prod_p1_q);
  assign res_w = sat_encode(prod_p1_q[PW-1], mag_w);

  // stage p0 -> p1: one extra bit keeps x - zp exact; product is full width
  always_ff @(posedge clk) begin
    if (en_i) begin
      diff_p0_q <= {x_i[DATA_W-1], x_i} - {zp_i[DATA_W-1], zp_i};
      prod_p1_q <= dx_w * ix_w;
    end
  end

  // stage p2: output register, reset to the zero digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_p2_q <= PENT_ZERO;
      sat_p2_q <= 1'b0;
    end else if (en_i) begin
      dig_p2_q <= res_w[2:0];
      sat_p2_q <= res_w[3];
    end
  end

  assign dig_o = dig_p2_q;
  assign sat_o = sat_p2_q;

endmodule

// File: rtl/pentary_quantizer_stream.sv
// Streaming LANES-wide pentary quantizer: valid chain, per-beat config capture, saturation stats.
module pentary_quantizer_stream
  import pentary_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int DATA_W = 32,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [DATA_W-1:0]       cfg_inv_scale,
  input  logic [DATA_W-1:0]       cfg_zero_point,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*3-1:0]      out_data,
  output logic [LANES-1:0]        out_sat,
  input  logic                    stat_clear,
  output logic [31:0]             sat_count
);

  localparam logic [DATA_W-1:0] INV_ONE = DATA_W'(1) << FRAC_W;

  logic              en;
  logic              vld_p0_q, vld_p1_q, vld_p2_q;
  logic [DATA_W-1:0] inv_q, inv_d, zp_q, zp_d;
  logic [DATA_W-1:0] inv_p0_q;
  logic [31:0]       sat_cnt_q, sat_cnt_d;
  logic [32:0]       sat_sum;

  assign en        = !vld_p2_q || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p2_q;
  assign sat_count = sat_cnt_q;

  assign inv_d = cfg_we ? cfg_inv_scale  : inv_q;
  assign zp_d  = cfg_we ? cfg_zero_point : zp_q;

  // Clear has priority over a same-cycle increment; the counter sticks at all-ones.
  always_comb begin
    sat_sum   = {1'b0, sat_cnt_q} + 33'($countones(out_sat));
    sat_cnt_d = sat_cnt_q;
    if (stat_clear)
      sat_cnt_d = '0;
    else if (out_valid && out_ready)
      sat_cnt_d = sat_sum[32] ? 32'hFFFF_FFFF : sat_sum[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      inv_q     <= INV_ONE;
      zp_q      <= '0;
      sat_cnt_q <= '0;
    end else begin
      inv_q     <= inv_d;
      zp_q      <= zp_d;
      sat_cnt_q <= sat_cnt_d;
      if (en) begin
        vld_p0_q <= in_valid;
        vld_p1_q <= vld_p0_q;
        vld_p2_q <= vld_p1_q;
      end
    end
  end

  // stage p0: inv_scale rides with the beat so later cfg writes cannot touch it
  always_ff @(posedge clk) begin
    if (en) inv_p0_q <= inv_q;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pentary_quant_lane #(
      .DATA_W(DATA_W),
      .FRAC_W(FRAC_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en),
      .x_i     (in_data[i*DATA_W +: DATA_W]),
      .zp_i    (zp_q),
      .inv_p0_i(inv_p0_q),
      .dig_o   (out_data[i*3 +: 3]),
      .sat_o   (out_sat[i])
    );
  end

endmodule

// File: tb/tb_pentary_quantizer_stream.sv
// Scoreboard bench for pentary_quantizer_stream with directed, hand-computed vectors.
module tb_pentary_quantizer_stream;

  localparam int L  = 16;
  localparam int DW = 32;
  localparam logic [31:0] ONE = 32'h0001_0000;

  typedef struct packed {
    logic [L*3-1:0] d;
    logic [L-1:0]   s;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_we;
  logic [DW-1:0]     cfg_inv_scale;
  logic [DW-1:0]     cfg_zero_point;
  logic              in_valid;
  logic              in_ready;
  logic [L*DW-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [L*3-1:0]    out_data;
  logic [L-1:0]      out_sat;
  logic              stat_clear;
  logic [31:0]       sat_count;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  logic        rnd = 1'b0;
  logic [31:0] vin[L];
  logic [2:0]  ed[L];
  logic [L-1:0] es;

  always #5 clk = ~clk;

  pentary_quantizer_stream dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_we        (cfg_we),
    .cfg_inv_scale (cfg_inv_scale),
    .cfg_zero_point(cfg_zero_point),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_sat       (out_sat),
    .stat_clear    (stat_clear),
    .sat_count     (sat_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [L*3-1:0] dig_all(input logic [2:0] d);
    logic [L*3-1:0] r;
    for (int i = 0; i < L; i++) r[i*3 +: 3] = d;
    return r;
  endfunction

  task automatic clr_vec();
    for (int i = 0; i < L; i++) begin
      vin[i] = 32'h0;
      ed[i]  = 3'b010;
    end
    es = '0;
  endtask

  task automatic fill_vec(input logic [31:0] v, input logic [2:0] d, input logic [L-1:0] s);
    for (int i = 0; i < L; i++) begin
      vin[i] = v;
      ed[i]  = d;
    end
    es = s;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic we, input logic [31:0] inv, input logic [31:0] zp);
    exp_t e;
    int   n;
    logic ok;
    for (int i = 0; i < L; i++) begin
      in_data[i*DW +: DW] = vin[i];
      e.d[i*3 +: 3]       = ed[i];
    end
    e.s            = es;
    in_valid       = 1'b1;
    cfg_we         = we;
    cfg_inv_scale  = inv;
    cfg_zero_point = zp;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end
    if (ok) sbq.push_back(e);
    else check("accept_timeout", 64'(ok), 64'd1);
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue_empty", 64'(sbq.size()), 64'd0);
  endtask

  // Monitor: pops on every handshake and checks that stalled outputs stay put.
  logic           stall_q = 1'b0;
  logic [L*3-1:0] held_d;
  logic [L-1:0]   held_s;
  exp_t           mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && out_valid) begin
        check("hold_data", 64'(out_data), 64'(held_d));
        check("hold_sat", 64'(out_sat), 64'(held_s));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          mon_e = sbq.pop_front();
          check("out_data", 64'(out_data), 64'(mon_e.d));
          check("out_sat", 64'(out_sat), 64'(mon_e.s));
        end
      end
      stall_q = out_valid && !out_ready;
      held_d  = out_data;
      held_s  = out_sat;
    end
  end

  always @(posedge clk) begin
    if (rnd) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int n;
    rst_n          = 1'b0;
    cfg_we         = 1'b0;
    cfg_inv_scale  = '0;
    cfg_zero_point = '0;
    in_valid       = 1'b0;
    in_data        = '0;
    out_ready      = 1'b1;
    stat_clear     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'(dig_all(3'b010)));
    check("rst_out_sat", 64'(out_sat), 64'd0);
    check("rst_sat_count", 64'(sat_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Defaults, with 3-edge latency
    clr_vec();
    vin[1] = ONE;          ed[1] = 3'b011;
    vin[2] = 32'h0002_0000; ed[2] = 3'b100;
    vin[3] = 32'hFFFF_0000; ed[3] = 3'b001;
    vin[4] = 32'hFFFE_0000; ed[4] = 3'b000;
    send(1'b0, 32'h0, 32'h0);
    @(negedge clk); check("lat_edge1", 64'(out_valid), 64'd0);
    @(negedge clk); check("lat_edge2", 64'(out_valid), 64'd0);
    @(negedge clk); check("lat_edge3", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    drain();

    // Rounding, half away from zero
    clr_vec();
    vin[0] = 32'h0000_6666; ed[0] = 3'b010;
    vin[1] = 32'h0000_999A; ed[1] = 3'b011;
    vin[2] = 32'h0001_8000; ed[2] = 3'b100;
    vin[3] = 32'hFFFF_8000; ed[3] = 3'b001;
    vin[4] = 32'hFFFE_8000; ed[4] = 3'b000;
    vin[5] = 32'h0002_7D71; ed[5] = 3'b100;
    send(1'b0, 32'h0, 32'h0);
    drain();

    // Clamp and saturation count
    clr_vec();
    vin[0] = 32'h0003_0000; ed[0] = 3'b100;
    vin[1] = 32'h000A_0000; ed[1] = 3'b100;
    vin[2] = 32'hFFFD_0000; ed[2] = 3'b000;
    vin[3] = 32'hFFF6_0000; ed[3] = 3'b000;
    es = 16'h000F;
    send(1'b0, 32'h0, 32'h0);
    drain();
    check("sat_count_4", 64'(sat_count), 64'd4);
    send(1'b0, 32'h0, 32'h0);
    drain();
    check("sat_count_8", 64'(sat_count), 64'd8);

    // Stall a saturating beat, then release it together with stat_clear
    out_ready = 1'b0;
    send(1'b0, 32'h0, 32'h0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("stall_out_valid", 64'(out_valid), 64'd1);
    repeat (3) begin @(posedge clk); #1; end
    check("stall_sat_count", 64'(sat_count), 64'd8);
    out_ready  = 1'b1;
    stat_clear = 1'b1;
    @(posedge clk); #1;
    stat_clear = 1'b0;
    check("clear_wins", 64'(sat_count), 64'd0);
    drain();

    // Random backpressure over 200 integer-valued beats
    rnd = 1'b1;
    for (int b = 0; b < 200; b++) begin
      for (int i = 0; i < L; i++) begin
        int k;
        k      = (i + b) % 5;
        vin[i] = 32'(k - 2) << 16;
        ed[i]  = 3'(k);
      end
      es = '0;
      send(1'b0, 32'h0, 32'h0);
    end
    rnd = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    // Config timing: new inv_scale only for beats accepted after the write cycle
    fill_vec(ONE, 3'b011, '0);
    send(1'b0, 32'h0, 32'h0);
    send(1'b1, 32'h0002_0000, 32'h0);
    fill_vec(ONE, 3'b100, '0);
    send(1'b0, 32'h0, 32'h0);
    send(1'b0, 32'h0, 32'h0);
    drain();

    // Zero point: write cycle uses old (2.0, 0); then (1.0, 1.0)
    fill_vec(ONE, 3'b100, '0);
    send(1'b1, ONE, ONE);
    fill_vec(ONE, 3'b010, '0);
    send(1'b0, 32'h0, 32'h0);
    fill_vec(32'h0005_0000, 3'b100, 16'hFFFF);
    send(1'b0, 32'h0, 32'h0);
    drain();
    check("sat_count_16", 64'(sat_count), 64'd16);

    // Reset with three beats in flight
    fill_vec(32'h0002_0000, 3'b011, '0);
    send(1'b0, 32'h0, 32'h0);
    send(1'b0, 32'h0, 32'h0);
    send(1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    sbq.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'(dig_all(3'b010)));
    check("midrst_out_sat", 64'(out_sat), 64'd0);
    check("midrst_sat_count", 64'(sat_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    fill_vec(ONE, 3'b011, '0);
    send(1'b0, 32'h0, 32'h0);
    fill_vec(32'hFFFE_0000, 3'b000, '0);
    send(1'b0, 32'h0, 32'h0);
    drain();
    check("post_rst_sat_count", 64'(sat_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pentary_quantizer_stream.md
# pentary_quantizer_stream

Parametrised, pipelined successor to the combinational 16-value pentary quantizer. Accepts a stream of LANES Q16.16 values per beat over a valid/ready handshake, computes round((x − zero_point) × inv_scale), clamps the result to [−2, +2] and emits 3-bit pentary digits. It runs at one beat per clock and counts saturation events. It sits between the activation and accumulator outputs and the pentary weight/activation buffers.

## Interface
- LANES, 16, values per beat
- DATA_W, 32, input word width, signed fixed-point
- FRAC_W, 16, fractional bits of inputs, zero point and inv_scale
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  load cfg_inv_scale and cfg_zero_point
- cfg_inv_scale  in  DATA_W  1/scale, signed Q(DATA_W−FRAC_W).FRAC_W
- cfg_zero_point  in  DATA_W  signed Q.FRAC_W
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  LANES*3  lane i at [i*3 +: 3]
- out_sat  out  LANES  lane i was clamped
- stat_clear  in  1  synchronous clear of sat_count
- sat_count  out  32  total clamped lanes, saturating

## Operation
- Digit encoding is offset binary: 000 = −2, 001 = −1, 010 = 0, 011 = +1, 100 = +2. Codes 101–111 are never produced.
- Config registers reset to inv_scale = 1.0 (1 << FRAC_W) and zero_point = 0. cfg_we can be asserted at any time.
- Config is captured with each accepted beat and travels down the pipeline with it. A beat accepted in the same cycle as cfg_we uses the old values. Beats accepted later use the new values. In-flight beats are never affected.
- Stage 1 computes diff = x − zp at DATA_W+1 bits, signed, with no overflow.
- Stage 2 computes prod = diff × inv_scale at 2·DATA_W+1 bits, signed, scaled by 2^(2·FRAC_W).
- Rounding is half away from zero: q = sign(prod) · floor((|prod| + 2^(2·FRAC_W−1)) >> 2·FRAC_W).
- Clamp: q > 2 gives +2 and q < −2 gives −2. In both cases out_sat[i] = 1.
- Stage 3 encodes the digit into the output register.
- sat_count adds popcount(out_sat) on each output handshake (out_valid && out_ready). It sticks at 0xFFFFFFFF.
- When stat_clear and an increment occur in the same cycle, clear wins and sat_count becomes 0.

## Timing
- The pipeline has 3 register stages and latency 3: a beat accepted in cycle t appears at out_valid in cycle t+3 if there is no stall.
- Each stage holds a valid bit. Global advance is en = !out_valid || out_ready.
- in_ready = en, which is combinational and has no in_valid → in_ready path.
- When en = 0, all stages hold. out_data and out_sat stay stable while out_valid && !out_ready.
- Throughput is 1 beat/clk under continuous out_ready. Bubbles propagate as invalid stages.
- Reset (asynchronous, any time, including mid-stream) sets:
  - all stage valids 0, so out_valid = 0;
  - out_data to all lanes 3'b010;
  - out_sat = 0 and sat_count = 0;
  - config to 1.0 and 0.
  - In-flight beats are discarded.
- in_ready is 1 in the first cycle after reset release.

## Structure
- Package pentary_pkg holds:
  - the PENT_NEG2..PENT_POS2 encoding constants;
  - the default FRAC_W;
  - a function pent_encode(int) returning 3 bits.
- Sub-module pentary_quant_lane holds the per-lane stage 1–3 datapath and sat flag, driven by a shared enable. It is generated LANES times.
- The top level owns the valid chain, the config capture and sat_count.

## Test plan
- Defaults (inv_scale 1.0, zp 0), lanes {0, 1.0, 2.0, −1.0, −2.0} → digits 010, 011, 100, 001, 000, out_sat 0, 3 cycles after accept.
- Rounding: lanes {0.4, 0.6, 1.5, −0.5, −1.5, 2.49} → {0, +1, +2, −1, −2, +2}, with out_sat = 0 on every lane.
- Clamp: lanes {3.0, 10.0, −3.0, −10.0}, rest 0 → {+2, +2, −2, −2}, out_sat = 0b1111, sat_count increments by 4 per beat.
- Config timing: stream beats of all 1.0; assert cfg_we with inv_scale 0x20000 (scale 0.5) and zp 0 on the second accept cycle → beats 1–2 give +1, beat 3 onward gives +2.
- Backpressure: random out_ready at 50% over 200 beats → output order and values match the model, with no loss or duplication and out_data held while stalled.
- Reset mid-stream with 3 beats in flight → out_valid 0, out_data 010 on all lanes, sat_count 0, config at 1.0/0; beats after release are correct. stat_clear coincident with a saturating beat → sat_count = 0.
